// File: rtl/swm_tx_arbiter.sv
// Two-requester Avalon-ST to SerialLite III TX packet arbiter: round-robin at packet
// boundaries, one-entry output register, sticky framing and oversize error flags.
module swm_tx_arbiter #(
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic        clk_in_clk,
  input  logic        reset_in_rst,
  input  logic [31:0] avalonst_sink0_data,
  input  logic        avalonst_sink0_valid,
  input  logic        avalonst_sink0_startofpacket,
  input  logic        avalonst_sink0_endofpacket,
  output logic        avalonst_sink0_ready,
  input  logic [31:0] avalonst_sink1_data,
  input  logic        avalonst_sink1_valid,
  input  logic        avalonst_sink1_startofpacket,
  input  logic        avalonst_sink1_endofpacket,
  output logic        avalonst_sink1_ready,
  output logic [63:0] data_tx,
  output logic        valid_tx,
  output logic        start_of_burst_tx,
  output logic        end_of_burst_tx,
  input  logic        ready_tx,
  input  logic        link_up,
  output logic        grant_id,
  output logic        oversize_err,
  output logic        framing_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [15:0] MAX_W = 16'(MAX_PKT_WORDS);

  logic [0:0]  state;
  logic        last_served;
  logic [15:0] word_cnt;
  logic [15:0] word_cnt_inc;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;

  logic        elig0;
  logic        elig1;
  logic        discard0;
  logic        discard1;
  logic        grant_req;
  logic        grant_sel;
  logic        g_valid;
  logic        g_sop;
  logic        g_eop;
  logic [31:0] g_data;
  logic        g_ready;
  logic        accept;

  assign elig0    = avalonst_sink0_valid && avalonst_sink0_startofpacket && link_up;
  assign elig1    = avalonst_sink1_valid && avalonst_sink1_startofpacket && link_up;
  assign discard0 = (state == IDLE) && avalonst_sink0_valid && !avalonst_sink0_startofpacket;
  assign discard1 = (state == IDLE) && avalonst_sink1_valid && !avalonst_sink1_startofpacket;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_req = (state == IDLE) && (elig0 || elig1);
    grant_sel = 1'b0;
    if (elig0 && elig1) begin
      grant_sel = ~last_served;
    end else if (elig1) begin
      grant_sel = 1'b1;
    end
  end

  assign g_valid = grant_id ? avalonst_sink1_valid         : avalonst_sink0_valid;
  assign g_sop   = grant_id ? avalonst_sink1_startofpacket : avalonst_sink0_startofpacket;
  assign g_eop   = grant_id ? avalonst_sink1_endofpacket   : avalonst_sink0_endofpacket;
  assign g_data  = grant_id ? avalonst_sink1_data          : avalonst_sink0_data;

  assign g_ready      = (state == BUSY) && (!out_valid || ready_tx);
  assign accept       = g_ready && g_valid && !reset_in_rst;
  assign word_cnt_inc = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;

  always_comb begin
    avalonst_sink0_ready = 1'b0;
    avalonst_sink1_ready = 1'b0;
    if (!reset_in_rst) begin
      if (state == IDLE) begin
        avalonst_sink0_ready = discard0;
        avalonst_sink1_ready = discard1;
      end else if (grant_id) begin
        avalonst_sink1_ready = g_ready;
      end else begin
        avalonst_sink0_ready = g_ready;
      end
    end
  end

  always_ff @(posedge clk_in_clk) begin
    if (reset_in_rst) begin
      state        <= IDLE;
      grant_id     <= 1'b0;
      last_served  <= 1'b1;
      word_cnt     <= 16'd0;
      out_valid    <= 1'b0;
      out_data     <= 32'd0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      oversize_err <= 1'b0;
      framing_err  <= 1'b0;
    end else begin
      if (discard0 || discard1) begin
        framing_err <= 1'b1;
      end
      if (grant_req) begin
        grant_id <= grant_sel;
        state    <= BUSY;
        word_cnt <= 16'd0;
      end
      // A simultaneous drain and load simply overwrites the register and keeps it full.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_sop   <= g_sop;
        out_eop   <= g_eop;
        word_cnt  <= word_cnt_inc;
        if (word_cnt_inc > MAX_W) begin
          oversize_err <= 1'b1;
        end
        if (g_sop && (word_cnt != 16'd0)) begin
          framing_err <= 1'b1;
        end
        if (g_eop) begin
          state       <= IDLE;
          last_served <= grant_id;
        end
      end else if (ready_tx) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign data_tx           = {32'h0, out_data};
  assign valid_tx          = out_valid && !reset_in_rst;
  assign start_of_burst_tx = out_valid && out_sop && !reset_in_rst;
  assign end_of_burst_tx   = out_valid && out_eop && !reset_in_rst;

endmodule
